// File: rtl/fifo_uart_tx_if.sv
// fifo_uart_tx_if: read port of the byte FIFO as seen by its single consumer.
// master = the consumer (issues ren), slave = the FIFO (returns empty/data).
interface fifo_uart_tx_if;
    logic       ren;
    logic       empty;
    logic [7:0] fifo_dout;

    modport master (output ren, input empty, input fifo_dout);
    modport slave  (input ren, output empty, output fifo_dout);
endinterface

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from the read side of a byte FIFO and serializes
// them as UART frames (start bit, 8 data bits LSB first, stop bit).
// Everything runs in the FIFO read-clock domain (rclk / rrst_n).
// Optional feature: define FIFO_UART_TX_PARITY_EN to insert an even-parity
// bit between the last data bit and the stop bit (11-bit frame).
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic           rclk,
    input  logic           rrst_n,
    input  logic           tx_en,
    fifo_uart_tx_if.master fifo,
    output logic           txd,
    output logic           busy
);

    localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_LOAD,
        S_START,
        S_DATA,
`ifdef FIFO_UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
`ifdef FIFO_UART_TX_PARITY_EN
    logic             parity_bit;
`endif

    logic bit_end;
    assign bit_end = (baud_cnt == CNT_LAST);

    // busy is a pure decode of the state so it drops together with reset.
    assign busy = (state != S_IDLE);

    // Frame sequencer: FIFO pop handshake, bit timing and the serial output.
    // NOTE: every register here uses <= so all of them update from the same
    // pre-edge values; the reset branch is asynchronous so txd goes high and
    // ren drops the moment rrst_n falls, not at the next clock.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state      <= S_IDLE;
            fifo.ren   <= 1'b0;
            txd        <= 1'b1;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift      <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    txd <= 1'b1;
                    if (tx_en && !fifo.empty) begin
                        fifo.ren <= 1'b1;
                        state    <= S_REQ;
                    end
                end

                // The FIFO sees ren=1 on this edge and presents the byte
                // on fifo_dout from here on; empty is not re-checked since
                // nobody else can drain the FIFO meanwhile.
                S_REQ: begin
                    fifo.ren <= 1'b0;
                    state    <= S_LOAD;
                end

                S_LOAD: begin
                    shift      <= fifo.fifo_dout;
`ifdef FIFO_UART_TX_PARITY_EN
                    parity_bit <= ^fifo.fifo_dout;
`endif
                    txd        <= 1'b0;
                    baud_cnt   <= '0;
                    bit_idx    <= '0;
                    state      <= S_START;
                end

                S_START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        txd      <= shift[0];
                        state    <= S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end

                S_DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
                            txd   <= parity_bit;
                            state <= S_PARITY;
`else
                            txd   <= 1'b1;
                            state <= S_STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shift   <= {1'b0, shift[7:1]};
                            txd     <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end

`ifdef FIFO_UART_TX_PARITY_EN
                S_PARITY: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        txd      <= 1'b1;
                        state    <= S_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
`endif

                S_STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        state    <= S_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    fifo.ren <= 1'b0;
                    txd      <= 1'b1;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: drives fifo_uart_tx from a small FIFO model and decodes
// txd with a UART line receiver derived from the frame format.
module tb_fifo_uart_tx;

    localparam int N = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC = FRAME_BITS * N;

    logic rclk   = 1'b0;
    logic rrst_n = 1'b0;
    logic tx_en  = 1'b0;
    logic txd;
    logic busy;

    fifo_uart_tx_if fif ();

    fifo_uart_tx #(.CLKS_PER_BIT(N)) dut (
        .rclk   (rclk),
        .rrst_n (rrst_n),
        .tx_en  (tx_en),
        .fifo   (fif),
        .txd    (txd),
        .busy   (busy)
    );

    always #5 rclk = ~rclk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- FIFO model ----------------
    logic [7:0] mem [0:255];
    logic [7:0] wr_ptr = '0;
    logic [7:0] rd_ptr = '0;
    int         ren_cnt = 0;
    logic [7:0] exp_q [$];

    assign fif.empty = (wr_ptr == rd_ptr);

    always @(posedge rclk) begin
        if (fif.ren && !fif.empty) begin
            fif.fifo_dout <= mem[rd_ptr];
            rd_ptr        <= rd_ptr + 8'd1;
        end
        if (fif.ren) ren_cnt <= ren_cnt + 1;
    end

    task automatic push_byte(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr      = wr_ptr + 8'd1;
        exp_q.push_back(b);
    endtask

    // ---------------- line receiver / reference ----------------
    function automatic logic [10:0] frame_bits(input logic [7:0] b);
        logic [10:0] fb;
        fb      = '1;
        fb[0]   = 1'b0;
        fb[8:1] = b;
`ifdef FIFO_UART_TX_PARITY_EN
        fb[9]   = ^b;
`endif
        return fb;
    endfunction

    logic [10:0] cur_bits = '1;
    int          in_frame = 0;
    int          pos      = 0;
    int          frames   = 0;
    int          idle_run = 0;
    bit          chk_gap  = 1'b0;
    logic        prev_ren = 1'b0;

    always @(negedge rclk) begin
        if (!rrst_n) begin
            in_frame = 0;
            pos      = 0;
            idle_run = 0;
            prev_ren = 1'b0;
        end else begin
            if (fif.ren === 1'b1) begin
                check("ren_single_cycle", prev_ren, 0);
                check("ren_fifo_nonempty", fif.empty, 0);
            end
            prev_ren = fif.ren;
            if (in_frame == 0 && txd === 1'b0) begin
                check("frame_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) cur_bits = frame_bits(exp_q.pop_front());
                else cur_bits = '1;
                if (chk_gap) check("gap_cycles", idle_run, 3);
                in_frame = 1;
                pos      = 0;
            end
            if (in_frame != 0) begin
                check($sformatf("txd_bit%0d", pos / N), txd, cur_bits[pos / N]);
                check("busy_in_frame", busy, 1);
                check("no_ren_in_frame", fif.ren, 0);
                pos++;
                if (pos == FRAME_CYC) begin
                    in_frame = 0;
                    frames++;
                    idle_run = 0;
                end
            end else begin
                idle_run++;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(negedge rclk);
        #1;
    endtask

    task automatic wait_frames(input int target, input int budget);
        int c = 0;
        while (frames < target && c < budget) begin
            tick();
            c++;
        end
        check("frames_done", frames >= target, 1);
    endtask

    task automatic wait_bit(input int bit_no, input int budget);
        int c = 0;
        while (!(in_frame != 0 && (pos / N) == bit_no) && c < budget) begin
            tick();
            c++;
        end
        check("reached_bit", (in_frame != 0 && (pos / N) == bit_no), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int f0;
        int r0;

        // Reset state
        repeat (3) tick();
        check("reset_outputs", {txd, fif.ren, busy}, 3'b100);
        rrst_n = 1'b1;
        tick();

        // Single byte 0xA5: one pop, frame checked bit by bit
        f0 = frames; r0 = ren_cnt;
        push_byte(8'hA5);
        tx_en = 1'b1;
        wait_frames(f0 + 1, FRAME_CYC + 20);
        repeat (3) tick();
        check("a5_ren_pulses", ren_cnt - r0, 1);
        check("a5_idle_after", {txd, busy}, 2'b10);

        // Empty FIFO with tx_en high: nothing happens
        for (int i = 0; i < 100; i++) begin
            tick();
            check("empty_idle", {fif.ren, txd, busy}, 3'b010);
        end

        // Three queued bytes back to back, 3-cycle gap between frames
        f0 = frames; r0 = ren_cnt;
        push_byte(8'h00);
        push_byte(8'hFF);
        push_byte(8'h3C);
        wait_frames(f0 + 1, FRAME_CYC + 20);
        chk_gap = 1'b1;
        wait_frames(f0 + 3, 2 * (FRAME_CYC + 10));
        chk_gap = 1'b0;
        repeat (3) tick();
        check("three_ren_pulses", ren_cnt - r0, 3);

        // tx_en falls during data bit 3 (frame bit 4) of 0x81
        f0 = frames; r0 = ren_cnt;
        push_byte(8'h81);
        push_byte(8'h42);
        wait_bit(4, FRAME_CYC + 20);
        tx_en = 1'b0;
        wait_frames(f0 + 1, FRAME_CYC + 20);
        for (int i = 0; i < 30; i++) begin
            tick();
            check("txen_low_idle", {fif.ren, busy}, 2'b00);
        end
        check("txen_low_one_pop", ren_cnt - r0, 1);
        tx_en = 1'b1;
        wait_frames(f0 + 2, FRAME_CYC + 20);
        check("txen_resume_pop", ren_cnt - r0, 2);

        // FIFO becomes non-empty during the stop bit: pop on first IDLE cycle
        f0 = frames;
        push_byte(8'($urandom));
        wait_bit(FRAME_BITS - 1, FRAME_CYC + 20);
        chk_gap = 1'b1;
        push_byte(8'($urandom));
        wait_frames(f0 + 2, 2 * (FRAME_CYC + 20));
        chk_gap = 1'b0;

        // Reset mid-frame: immediate idle, popped byte dropped, no pop in reset
        f0 = frames;
        push_byte(8'($urandom));
        push_byte(8'($urandom));
        wait_bit(2, FRAME_CYC + 20);
        #2 rrst_n = 1'b0;
        #1 check("rst_async", {txd, fif.ren, busy}, 3'b100);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rst_hold", {txd, fif.ren, busy}, 3'b100);
        end
        rrst_n = 1'b1;
        tick();
        check("first_ren_after_rst", fif.ren, 1);
        wait_frames(f0 + 1, FRAME_CYC + 20);

        // Randomized bytes with random arrival spacing
        f0 = frames; r0 = ren_cnt;
        for (int i = 0; i < 12; i++) begin
            push_byte(8'($urandom));
            repeat ($urandom_range(0, FRAME_CYC + 10)) tick();
        end
        wait_frames(f0 + 12, 12 * (FRAME_CYC + 10) + 100);
        repeat (3) tick();
        check("random_ren_pulses", ren_cnt - r0, 12);
        check("all_bytes_sent", exp_q.size(), 0);
        check("final_idle", {txd, fif.ren, busy}, 3'b100);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
